// File: rtl/collision_scanner.sv
// collision_scanner: walks the invader grid one cell per clock, killing invaders hit by captured
// projectiles, then checks whether the lowest surviving row has reached the player line.
module collision_scanner #(
    parameter int unsigned NUM_INVADERS      = 10,
    parameter int unsigned NUM_ROWS          = 3,
    parameter int unsigned NUM_PROJ          = 4,
    parameter int unsigned ROW_OFFSET        = 100,
    parameter int unsigned INVADER_WIDTH     = 64,
    parameter int unsigned INVADER_HEIGHT    = 32,
    parameter int unsigned PROJECTILE_WIDTH  = 16,
    parameter int unsigned PROJECTILE_HEIGHT = 32,
    parameter int unsigned LOSE_Y            = 568,
    localparam int unsigned NUM_CELLS        = NUM_ROWS * NUM_INVADERS,
    localparam int unsigned KW               = $clog2(NUM_CELLS + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   revive,
    input  logic [NUM_PROJ-1:0][11:0]              projectile_xpos,
    input  logic [NUM_PROJ-1:0][11:0]              projectile_ypos,
    input  logic [NUM_PROJ-1:0]                    projectile_active,
    input  logic [NUM_INVADERS-1:0][11:0]          invader_x_positions,
    input  logic [9:0]                             enemy_ypos,
    output logic [NUM_ROWS-1:0][NUM_INVADERS-1:0]  alive,
    output logic [NUM_PROJ-1:0]                    proj_hit,
    output logic [KW-1:0]                          kill_count,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   player_hit,
    output logic                                   all_dead
);

    localparam int unsigned RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned CW = (NUM_INVADERS > 1) ? $clog2(NUM_INVADERS) : 1;

    localparam logic [12:0] InvW  = 13'(INVADER_WIDTH);
    localparam logic [12:0] InvH  = 13'(INVADER_HEIGHT);
    localparam logic [12:0] PrjW  = 13'(PROJECTILE_WIDTH);
    localparam logic [12:0] PrjH  = 13'(PROJECTILE_HEIGHT);
    localparam logic [12:0] LoseY = 13'(LOSE_Y);

    typedef enum logic [1:0] {StIdle, StScan, StCheck, StDone} state_e;

    state_e                                 state_q, state_d;
    logic [NUM_ROWS-1:0][NUM_INVADERS-1:0]  alive_q, alive_d;
    logic [NUM_PROJ-1:0]                    consumed_q, consumed_d;
    logic [NUM_PROJ-1:0]                    proj_hit_q, proj_hit_d;
    logic [KW-1:0]                          kill_q, kill_d;
    logic                                   player_hit_q, player_hit_d;
    logic [RW-1:0]                          row_q, row_d;
    logic [CW-1:0]                          col_q, col_d;
    logic                                   capture;

    logic [NUM_PROJ-1:0][11:0]              px_q, py_q;
    logic [NUM_PROJ-1:0]                    pact_q;
    logic [NUM_INVADERS-1:0][11:0]          inv_x_q;
    logic [9:0]                             ey_q;

    logic [12:0]                            cell_x, cell_y, px, py;
    logic [NUM_PROJ-1:0]                    win_vec;
    logic                                   hit_found;
    logic [12:0]                            low_y;
    logic                                   low_found;
    logic                                   lose;

    // All 13-bit: 12-bit positions plus hitbox sizes never overflow.
    assign cell_x = {1'b0, inv_x_q[col_q]};
    assign cell_y = {3'b000, ey_q} + 13'(row_q * ROW_OFFSET);

    // Lowest-index qualifying projectile wins the current cell.
    always_comb begin
        win_vec   = '0;
        hit_found = 1'b0;
        px        = '0;
        py        = '0;
        for (int p = 0; p < NUM_PROJ; p++) begin
            px = {1'b0, px_q[p]};
            py = {1'b0, py_q[p]};
            if (!hit_found && pact_q[p] && !consumed_q[p] &&
                (px <= cell_x + InvW) && (px + PrjW >= cell_x) &&
                (py <= cell_y + InvH) && (py + PrjH >= cell_y)) begin
                hit_found  = 1'b1;
                win_vec[p] = 1'b1;
            end
        end
    end

    always_comb begin
        low_found = 1'b0;
        low_y     = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (|alive_q[r]) begin
                low_found = 1'b1;
                low_y     = {3'b000, ey_q} + 13'(r * ROW_OFFSET);
            end
        end
    end

    assign lose = low_found && (low_y + InvH >= LoseY);

    always_comb begin
        state_d      = state_q;
        alive_d      = alive_q;
        consumed_d   = consumed_q;
        proj_hit_d   = proj_hit_q;
        kill_d       = kill_q;
        player_hit_d = player_hit_q;
        row_d        = row_q;
        col_d        = col_q;
        capture      = 1'b0;
        case (state_q)
            StIdle: begin
                if (revive) begin
                    alive_d      = '1;
                    player_hit_d = 1'b0;
                end else if (start) begin
                    capture    = 1'b1;
                    state_d    = StScan;
                    row_d      = '0;
                    col_d      = '0;
                    consumed_d = '0;
                    proj_hit_d = '0;
                    kill_d     = '0;
                end
            end
            StScan: begin
                if (alive_q[row_q][col_q] && hit_found) begin
                    alive_d[row_q][col_q] = 1'b0;
                    consumed_d            = consumed_q | win_vec;
                    proj_hit_d            = proj_hit_q | win_vec;
                    kill_d                = kill_q + KW'(1);
                end
                if (col_q == CW'(NUM_INVADERS - 1)) begin
                    col_d = '0;
                    if (row_q == RW'(NUM_ROWS - 1)) begin
                        state_d = StCheck;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            StCheck: begin
                if (lose) begin
                    player_hit_d = 1'b1;
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            alive_q      <= '1;
            consumed_q   <= '0;
            proj_hit_q   <= '0;
            kill_q       <= '0;
            player_hit_q <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
        end else begin
            state_q      <= state_d;
            alive_q      <= alive_d;
            consumed_q   <= consumed_d;
            proj_hit_q   <= proj_hit_d;
            kill_q       <= kill_d;
            player_hit_q <= player_hit_d;
            row_q        <= row_d;
            col_q        <= col_d;
        end
    end

    // Scan works only from the snapshot taken at start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_q    <= '0;
            py_q    <= '0;
            pact_q  <= '0;
            inv_x_q <= '0;
            ey_q    <= '0;
        end else if (capture) begin
            px_q    <= projectile_xpos;
            py_q    <= projectile_ypos;
            pact_q  <= projectile_active;
            inv_x_q <= invader_x_positions;
            ey_q    <= enemy_ypos;
        end
    end

    assign alive      = alive_q;
    assign proj_hit   = proj_hit_q;
    assign kill_count = kill_q;
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign player_hit = player_hit_q;
    assign all_dead   = ~|alive_q;

endmodule

// File: tb/tb_collision_scanner.sv
// Self-checking bench for collision_scanner: directed scenarios plus randomized scans against a
// grid-level reference model.
module tb_collision_scanner;

    logic             clk, rst, start, revive;
    logic [3:0][11:0] pxp, pyp;
    logic [3:0]       pact;
    logic [9:0][11:0] invx;
    logic [9:0]       eyp;
    logic [2:0][9:0]  alive;
    logic [3:0]       proj_hit;
    logic [4:0]       kill_count;
    logic             busy, done, player_hit, all_dead;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int       s_px[4], s_py[4], s_x[10], s_ey;
    bit       s_act[4];
    bit       m_alive[3][10];
    bit       m_ph;
    bit [3:0] m_phit;
    int       m_kills;

    collision_scanner dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .revive              (revive),
        .projectile_xpos     (pxp),
        .projectile_ypos     (pyp),
        .projectile_active   (pact),
        .invader_x_positions (invx),
        .enemy_ypos          (eyp),
        .alive               (alive),
        .proj_hit            (proj_hit),
        .kill_count          (kill_count),
        .busy                (busy),
        .done                (done),
        .player_hit          (player_hit),
        .all_dead            (all_dead)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit ov(int px, int py, int x, int y);
        return (px <= x + 64) && (px + 16 >= x) && (py <= y + 32) && (py + 32 >= y);
    endfunction

    function automatic logic [29:0] model_vec();
        logic [29:0] v;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 10; c++) v[r*10+c] = m_alive[r][c];
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 10; c++) m_alive[r][c] = 1'b1;
        m_ph = 1'b0;
    endtask

    task automatic take_snapshot();
        for (int p = 0; p < 4; p++) begin
            s_px[p] = int'(pxp[p]); s_py[p] = int'(pyp[p]); s_act[p] = pact[p];
        end
        for (int c = 0; c < 10; c++) s_x[c] = int'(invx[c]);
        s_ey = int'(eyp);
    endtask

    task automatic model_scan();
        bit cons[4];
        bit found;
        for (int p = 0; p < 4; p++) cons[p] = 1'b0;
        m_phit = '0;
        m_kills = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 10; c++)
                for (int p = 0; p < 4; p++)
                    if (m_alive[r][c] && s_act[p] && !cons[p] &&
                        ov(s_px[p], s_py[p], s_x[c], s_ey + r * 100)) begin
                        m_alive[r][c] = 1'b0;
                        cons[p] = 1'b1;
                        m_phit[p] = 1'b1;
                        m_kills++;
                    end
        found = 1'b0;
        for (int r = 2; r >= 0; r--) begin
            bit any = 1'b0;
            for (int c = 0; c < 10; c++) any |= m_alive[r][c];
            if (any && !found) begin
                found = 1'b1;
                if (s_ey + r * 100 + 32 >= 568) m_ph = 1'b1;
            end
        end
    endtask

    task automatic set_defaults();
        eyp = 10'd50;
        for (int c = 0; c < 10; c++) invx[c] = 12'(c * 80);
        pact = '0;
        pxp = '0;
        pyp = '0;
    endtask

    task automatic randomize_inputs();
        eyp = 10'($urandom_range(0, 450));
        for (int c = 0; c < 10; c++) invx[c] = 12'(c * 80 + $urandom_range(0, 10));
        pact = 4'($urandom);
        for (int p = 0; p < 4; p++) begin
            int r = $urandom_range(0, 2);
            int c = $urandom_range(0, 9);
            int x = c * 80 + $urandom_range(0, 100) - 30;
            int y = int'(eyp) + r * 100 + $urandom_range(0, 70) - 40;
            pxp[p] = 12'((x < 0) ? 0 : x);
            pyp[p] = 12'((y < 0) ? 0 : y);
        end
    endtask

    // Runs one scan; returns cycles from the start edge to the first done (100 on timeout).
    task automatic do_scan(input bit scramble, output int cyc);
        take_snapshot();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (scramble) randomize_inputs();
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 100);
        model_scan();
    endtask

    task automatic do_revive();
        @(negedge clk);
        revive = 1'b1;
        @(posedge clk);
        #1 revive = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; revive = 1'b0;
        set_defaults();
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (alive !== 30'h3fff_ffff) begin
            n_errors++; $display("FAIL reset_alive: got %h expected 3fffffff", alive);
        end
        n_checks++;
        if ({busy, done, player_hit, all_dead} !== 4'b0000) begin
            n_errors++; $display("FAIL reset_flags: got %b expected 0000",
                                 {busy, done, player_hit, all_dead});
        end
        n_checks++;
        if ({proj_hit, kill_count} !== 9'd0) begin
            n_errors++; $display("FAIL reset_counts: got %h/%0d expected 0/0", proj_hit, kill_count);
        end
    endtask

    task automatic test_single_kill();
        int cyc;
        set_defaults();
        pxp[0] = 12'd85; pyp[0] = 12'd60; pact = 4'b0001;
        do_scan(1'b0, cyc);
        n_checks++;
        if (cyc !== 32) begin
            n_errors++; $display("FAIL single_latency: got %0d expected 32", cyc);
        end
        n_checks++;
        if (alive !== model_vec() || alive[0][1] !== 1'b0) begin
            n_errors++; $display("FAIL single_alive: got %h expected %h", alive, model_vec());
        end
        n_checks++;
        if (proj_hit !== 4'b0001 || kill_count !== 5'd1) begin
            n_errors++; $display("FAIL single_result: got %b/%0d expected 0001/1",
                                 proj_hit, kill_count);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++; $display("FAIL single_busy_done: got %b expected 1", busy);
        end
        @(negedge clk);
        n_checks++;
        if ({done, busy} !== 2'b00) begin
            n_errors++; $display("FAIL single_done_pulse: got %b expected 00", {done, busy});
        end
    endtask

    task automatic test_shared_target();
        int cyc;
        do_revive();
        set_defaults();
        pxp[0] = 12'd5; pyp[0] = 12'd55; pxp[1] = 12'd5; pyp[1] = 12'd55; pact = 4'b0011;
        do_scan(1'b0, cyc);
        n_checks++;
        if (alive !== model_vec() || alive !== 30'h3fff_fffe) begin
            n_errors++; $display("FAIL shared_alive: got %h expected %h", alive, model_vec());
        end
        n_checks++;
        if (proj_hit !== 4'b0001 || kill_count !== 5'd1) begin
            n_errors++; $display("FAIL shared_result: got %b/%0d expected 0001/1",
                                 proj_hit, kill_count);
        end
    endtask

    task automatic test_two_kills();
        int cyc;
        do_revive();
        set_defaults();
        pxp[0] = 12'd5; pyp[0] = 12'd55; pxp[2] = 12'd165; pyp[2] = 12'd155; pact = 4'b0101;
        do_scan(1'b0, cyc);
        n_checks++;
        if (alive !== model_vec() || alive[0][0] !== 1'b0 || alive[1][2] !== 1'b0) begin
            n_errors++; $display("FAIL two_alive: got %h expected %h", alive, model_vec());
        end
        n_checks++;
        if (proj_hit !== 4'b0101 || kill_count !== 5'd2) begin
            n_errors++; $display("FAIL two_result: got %b/%0d expected 0101/2",
                                 proj_hit, kill_count);
        end
    endtask

    task automatic test_boundary();
        int cyc;
        for (int k = 0; k < 2; k++) begin
            do_revive();
            set_defaults();
            pxp[0] = 12'(144 + k); pyp[0] = 12'd55; pact = 4'b0001;
            do_scan(1'b0, cyc);
            n_checks++;
            if (alive !== model_vec() || alive[0][1] !== 1'(k)) begin
                n_errors++; $display("FAIL boundary_px%0d: got %h expected %h",
                                     144 + k, alive, model_vec());
            end
        end
    endtask

    task automatic test_lose_revive();
        int cyc;
        int ys[3] = '{335, 336, 400};
        for (int k = 0; k < 3; k++) begin
            do_revive();
            set_defaults();
            eyp = 10'(ys[k]);
            do_scan(1'b0, cyc);
            n_checks++;
            if (player_hit !== m_ph || player_hit !== (k != 0)) begin
                n_errors++; $display("FAIL lose_ey%0d: got %b expected %b",
                                     ys[k], player_hit, m_ph);
            end
        end
        do_revive();
        n_checks++;
        if (player_hit !== 1'b0 || alive !== 30'h3fff_ffff) begin
            n_errors++; $display("FAIL revive_restore: got %b/%h expected 0/3fffffff",
                                 player_hit, alive);
        end
    endtask

    task automatic test_all_dead();
        int cyc;
        do_revive();
        set_defaults();
        eyp = 10'd400;
        do_scan(1'b0, cyc);
        for (int it = 0; it < 10 && model_vec() != 30'd0; it++) begin
            int k = 0;
            pact = '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 10; c++)
                    if (m_alive[r][c] && k < 4) begin
                        pxp[k] = 12'(c * 80); pyp[k] = 12'(400 + r * 100); pact[k] = 1'b1; k++;
                    end
            do_scan(1'b0, cyc);
            n_checks++;
            if (cyc !== 32 || alive !== model_vec() || kill_count !== 5'(m_kills)) begin
                n_errors++; $display("FAIL clear_scan%0d: got %0d/%h/%0d expected 32/%h/%0d",
                                     it, cyc, alive, kill_count, model_vec(), m_kills);
            end
        end
        n_checks++;
        if (all_dead !== 1'b1 || alive !== 30'd0) begin
            n_errors++; $display("FAIL all_dead: got %b/%h expected 1/0", all_dead, alive);
        end
        n_checks++;
        if (player_hit !== 1'b1) begin
            n_errors++; $display("FAIL no_live_keeps_hit: got %b expected 1", player_hit);
        end
    endtask

    task automatic test_busy_ignores();
        int ndone = 0;
        int first = 0;
        do_revive();
        set_defaults();
        pxp[0] = 12'd85; pyp[0] = 12'd60; pact = 4'b0001;
        take_snapshot();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 70; cyc++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first == 0) first = cyc;
            end
            start  = (cyc == 10);
            revive = (cyc == 12);
        end
        model_scan();
        n_checks++;
        if (ndone !== 1 || first !== 32) begin
            n_errors++; $display("FAIL start_while_busy: got %0d dones at %0d expected 1 at 32",
                                 ndone, first);
        end
        n_checks++;
        if (alive !== model_vec() || player_hit !== m_ph) begin
            n_errors++; $display("FAIL revive_while_busy: got %h expected %h", alive, model_vec());
        end
        pxp[0] = 12'd5; pyp[0] = 12'd55;
        take_snapshot();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(negedge clk);
        n_checks++;
        if (alive[0][0] !== 1'b0 || busy !== 1'b1) begin
            n_errors++; $display("FAIL midscan_kill: got %b/%b expected 0/1", alive[0][0], busy);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || alive !== 30'h3fff_ffff || player_hit !== 1'b0) begin
            n_errors++; $display("FAIL midscan_reset: got %b%b%b/%h expected 000/3fffffff",
                                 busy, done, player_hit, alive);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        n_checks++;
        if (ndone !== 0) begin
            n_errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", ndone);
        end
    endtask

    task automatic test_random();
        int cyc;
        do_revive();
        for (int it = 0; it < 24; it++) begin
            if (it % 6 == 5) do_revive();
            randomize_inputs();
            do_scan(1'b1, cyc);
            n_checks++;
            if (cyc !== 32 || alive !== model_vec()) begin
                n_errors++; $display("FAIL rand%0d_alive: got %0d/%h expected 32/%h",
                                     it, cyc, alive, model_vec());
            end
            n_checks++;
            if (proj_hit !== m_phit || kill_count !== 5'(m_kills)) begin
                n_errors++; $display("FAIL rand%0d_hits: got %b/%0d expected %b/%0d",
                                     it, proj_hit, kill_count, m_phit, m_kills);
            end
            n_checks++;
            if (player_hit !== m_ph || all_dead !== (model_vec() == 30'd0)) begin
                n_errors++; $display("FAIL rand%0d_flags: got %b/%b expected %b/%b", it,
                                     player_hit, all_dead, m_ph, (model_vec() == 30'd0));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_kill();
        test_shared_target();
        test_two_kills();
        test_boundary();
        test_lose_revive();
        test_all_dead();
        test_busy_ignores();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/collision_scanner.md
COLLISION_SCANNER -- requirements
Module: collision_scanner

Interface
REQ-001 Parameter NUM_INVADERS, 10, invader columns per row.
REQ-002 Parameter NUM_ROWS, 3, invader rows.
REQ-003 Parameter NUM_PROJ, 4, independent player projectiles checked per scan.
REQ-004 Parameter ROW_OFFSET, 100, vertical pixel pitch between rows.
REQ-005 Parameters INVADER_WIDTH 64, INVADER_HEIGHT 32, PROJECTILE_WIDTH 16, PROJECTILE_HEIGHT 32, hitbox sizes in pixels.
REQ-006 Parameter LOSE_Y, 568, pixel row; a live invader bottom at or below it means the player is hit.
REQ-007 clk  input  1  single system clock; all state changes on its rising edge.
REQ-008 rst  input  1  reset, asynchronous and active-high.
REQ-009 start  input  1  one-cycle request to run one collision scan.
REQ-010 revive  input  1  one-cycle request to restore all invaders and clear player_hit.
REQ-011 projectile_xpos  input  NUM_PROJ x 12  projectile left edges.
REQ-012 projectile_ypos  input  NUM_PROJ x 12  projectile top edges.
REQ-013 projectile_active  input  NUM_PROJ  per-projectile valid.
REQ-014 invader_x_positions  input  NUM_INVADERS x 12  column left edges, shared by all rows.
REQ-015 enemy_ypos  input  10  top edge of row 0.
REQ-016 alive  output  NUM_ROWS x NUM_INVADERS  registered live mask.
REQ-017 proj_hit  output  NUM_PROJ  per-projectile hit flags, valid only while done=1.
REQ-018 kill_count  output  $clog2(NUM_ROWS*NUM_INVADERS+1)  invaders killed by the last scan, valid while done=1.
REQ-019 busy  output  1  high in any state other than IDLE.
REQ-020 done  output  1  one-cycle pulse at scan completion.
REQ-021 player_hit  output  1  sticky lose flag.
REQ-022 all_dead  output  1  high when alive is all zeros.

Function
REQ-023 FSM states IDLE, SCAN, CHECK, DONE; IDLE->SCAN on start; SCAN->CHECK after last cell; CHECK->DONE; DONE->IDLE unconditionally.
REQ-024 On start in IDLE, all projectile, invader and enemy_ypos inputs shall be captured into registers; the scan uses only the captured values.
REQ-025 SCAN shall visit one cell per cycle, row 0 col 0 first, column-major within a row, for exactly NUM_ROWS*NUM_INVADERS cycles.
REQ-026 Cell (r,c) hitbox: x = inv_x[c], y = enemy_ypos + r*ROW_OFFSET; all hitbox arithmetic in 13-bit unsigned, no wrap.
REQ-027 Overlap is inclusive: px <= x+INVADER_WIDTH and px+PROJECTILE_WIDTH >= x and py <= y+INVADER_HEIGHT and py+PROJECTILE_HEIGHT >= y.
REQ-028 A cell is killed only if alive, and some projectile is active, not yet consumed this scan and overlapping; the lowest-index such projectile wins.
REQ-029 A kill clears alive[r][c] on the next edge, sets that projectile's consumed flag and proj_hit bit, increments kill_count.
REQ-030 Each projectile kills at most one invader per scan; consumed flags, proj_hit and kill_count clear on scan start.
REQ-031 CHECK finds the highest row index with any alive bit; if found and its bottom (y+INVADER_HEIGHT) >= LOSE_Y, player_hit sets.
REQ-032 No live invader in CHECK leaves player_hit unchanged.
REQ-033 done is high exactly in DONE; start-to-done latency is NUM_ROWS*NUM_INVADERS+2 cycles after the start edge.
REQ-034 start while busy shall be ignored and not queued.
REQ-035 revive in IDLE sets alive all ones and clears player_hit next edge; revive while busy is ignored; revive and start together in IDLE: revive applies, start is ignored.
REQ-036 player_hit remains set until rst or revive.
REQ-037 all_dead is combinational from alive.

Reset
REQ-038 rst shall asynchronously force state IDLE, alive all ones, proj_hit 0, kill_count 0, consumed 0, busy 0, done 0, player_hit 0.
REQ-039 rst asserted mid-scan shall abort the scan with no done pulse; scanning resumes only on a new start.

Verification
REQ-040 Defaults, enemy_ypos=50, inv_x[c]=c*80, proj0 active at (85,60), start -> done after 32 cycles; alive[0][1]=0, proj_hit=0001, kill_count=1.
REQ-041 proj0 and proj1 both at (5,55), start -> alive[0][0]=0 only; proj_hit=0001; proj1 unconsumed, kill_count=1.
REQ-042 proj0 at (5,55) with x extent covering cols 0 only; proj2 at (165,155) -> cells (0,0),(1,2) cleared, proj_hit=0101, kill_count=2.
REQ-043 enemy_ypos=400, all alive, start -> row 2 bottom 632 >= 568, player_hit=1; kill row 2 by revive-free scans irrelevant; revive -> player_hit=0, alive all ones.
REQ-044 start pulsed again at cycle 10 of a scan -> ignored, exactly one done; rst at cycle 15 -> busy=0, alive all ones, no done.
REQ-045 Boundary: projectile at px = x+64 exactly overlaps (kill); px = x+65 does not.
